// File: rtl/fu_mem_pipe.sv
// Memory functional unit: rs1+imm addressing, byte/half/word loads and stores on a
// byte-lane array, tagged result after LATENCY cycles, pipelined or blocking issue.
module fu_mem_pipe #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned PIPELINED   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    output logic             ready,
    input  logic             mem_w,
    input  logic [2:0]       bhw,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic [31:0]      imm,
    input  logic [TAG_W-1:0] tag_in,
    output logic [31:0]      mem_data,
    output logic [TAG_W-1:0] tag_out,
    output logic             finish,
    output logic             fault
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned NSTG = LATENCY - 1;
    localparam int unsigned CW   = $clog2(LATENCY);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic             valid;
        logic             fault;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } res_t;

    logic             r_ready;
    logic [CW-1:0]    r_busy;

    logic             r_s1_valid;
    logic             r_s1_we;
    logic [2:0]       r_s1_bhw;
    logic [31:0]      r_s1_rs1;
    logic [31:0]      r_s1_rs2;
    logic [31:0]      r_s1_imm;
    logic [TAG_W-1:0] r_s1_tag;

    logic [3:0][7:0]  r_mem [DEPTH_WORDS];
    res_t             r_stg [NSTG];

    logic             w_accept;
    logic [31:0]      w_addr;
    logic [AW-1:0]    w_idx;
    logic [1:0]       w_sz;
    logic             w_illegal;
    logic             w_misalign;
    logic             w_fault;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_we;
    logic [31:0]      w_rword;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic             w_uns;
    logic [31:0]      w_ext;
    logic [31:0]      w_ldata;
    logic             w_unused_addr;

    assign w_accept      = EN & r_ready;
    assign ready         = r_ready;
    assign w_addr        = r_s1_rs1 + r_s1_imm;
    assign w_idx         = w_addr[AW+1:2];
    assign w_unused_addr = ^w_addr[31:AW+2];

    // Issue gate: always open when pipelined, otherwise closed for LATENCY-1 cycles per op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_busy  <= '0;
        end else if (PIPELINED != 0) begin
            r_ready <= 1'b1;
        end else if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= CW'(LATENCY - 1);
        end else if (!r_ready) begin
            if (r_busy <= CW'(1)) begin
                r_ready <= 1'b1;
                r_busy  <= '0;
            end else begin
                r_busy  <= r_busy - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_bhw   <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_imm   <= '0;
            r_s1_tag   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_we  <= mem_w;
                r_s1_bhw <= bhw;
                r_s1_rs1 <= rs1_data;
                r_s1_rs2 <= rs2_data;
                r_s1_imm <= imm;
                r_s1_tag <= tag_in;
            end
        end
    end

    // Access size decode and fault detection
    always_comb begin
        w_sz      = SZ_B;
        w_illegal = 1'b0;
        if (r_s1_we) begin
            case (r_s1_bhw[1:0])
                2'b00:   w_sz = SZ_B;
                2'b01:   w_sz = SZ_H;
                2'b10:   w_sz = SZ_W;
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (r_s1_bhw)
                3'b000, 3'b100: w_sz = SZ_B;
                3'b001, 3'b101: w_sz = SZ_H;
                3'b010:         w_sz = SZ_W;
                default:        w_illegal = 1'b1;
            endcase
        end
        w_misalign = ((w_sz == SZ_H) & w_addr[0]) | ((w_sz == SZ_W) & (|w_addr[1:0]));
        w_fault    = w_illegal | w_misalign;
    end

    // Store lane enables with data replicated across lanes
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_s1_rs2;
        case (w_sz)
            SZ_B: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wdata = {4{r_s1_rs2[7:0]}};
            end
            SZ_H: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_s1_rs2[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_s1_rs2;
            end
        endcase
    end

    assign w_we = r_s1_valid & r_s1_we & ~w_fault & rst_n;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Lane extraction and sign/zero extension of the read word
    always_comb begin
        w_rword = r_mem[w_idx];
        w_byte  = w_rword[{w_addr[1:0], 3'b000} +: 8];
        w_half  = w_addr[1] ? w_rword[31:16] : w_rword[15:0];
        w_uns   = r_s1_bhw[2];
        case (w_sz)
            SZ_B:    w_ext = {{24{~w_uns & w_byte[7]}}, w_byte};
            SZ_H:    w_ext = {{16{~w_uns & w_half[15]}}, w_half};
            default: w_ext = w_rword;
        endcase
        w_ldata = (r_s1_valid & ~r_s1_we & ~w_fault) ? w_ext : 32'h0;
    end

    // Access-stage result followed by LATENCY-2 delay stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSTG); i++) begin
                r_stg[i] <= '0;
            end
        end else begin
            r_stg[0].valid <= r_s1_valid;
            r_stg[0].fault <= r_s1_valid & w_fault;
            r_stg[0].tag   <= r_s1_valid ? r_s1_tag : '0;
            r_stg[0].data  <= w_ldata;
            for (int i = 1; i < int'(NSTG); i++) begin
                r_stg[i] <= r_stg[i-1];
            end
        end
    end

    assign finish   = r_stg[NSTG-1].valid;
    assign fault    = r_stg[NSTG-1].fault;
    assign tag_out  = r_stg[NSTG-1].tag;
    assign mem_data = r_stg[NSTG-1].data;

endmodule

// File: tb/tb_fu_mem_pipe.sv
// Bench for fu_mem_pipe: a pipelined LATENCY=2 instance (d=0) and a blocking LATENCY=4
// instance (d=1), checked against a byte-array reference model with a completion queue.
module tb_fu_mem_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en    [2];
    logic        mw    [2];
    logic [2:0]  bhw_i [2];
    logic [31:0] rs1   [2];
    logic [31:0] rs2   [2];
    logic [31:0] immv  [2];
    logic [4:0]  tagi  [2];
    logic        rdy   [2];
    logic        fin   [2];
    logic        flt   [2];
    logic [31:0] md    [2];
    logic [4:0]  tago  [2];

    fu_mem_pipe #(.DEPTH_WORDS(1024), .LATENCY(2), .TAG_W(5), .PIPELINED(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .EN(en[0]), .ready(rdy[0]), .mem_w(mw[0]),
        .bhw(bhw_i[0]), .rs1_data(rs1[0]), .rs2_data(rs2[0]), .imm(immv[0]),
        .tag_in(tagi[0]), .mem_data(md[0]), .tag_out(tago[0]), .finish(fin[0]),
        .fault(flt[0]));

    fu_mem_pipe #(.DEPTH_WORDS(1024), .LATENCY(4), .TAG_W(5), .PIPELINED(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .EN(en[1]), .ready(rdy[1]), .mem_w(mw[1]),
        .bhw(bhw_i[1]), .rs1_data(rs1[1]), .rs2_data(rs2[1]), .imm(immv[1]),
        .tag_in(tagi[1]), .mem_data(md[1]), .tag_out(tago[1]), .finish(fin[1]),
        .fault(flt[1]));

    typedef struct {
        int          due;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  bmem [2][4096];
    int          cyc;
    int          last_acc [2];
    int          vectors;
    int          errors;
    bit          drop_mode;
    logic [31:0] got_data;
    logic [4:0]  got_tag;
    logic        got_fault;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    // Reference: resolve the op in acceptance order against a flat byte array
    function automatic void model_accept(input int d);
        logic [31:0] a;
        logic [31:0] v;
        int          sz;
        bit          ill;
        bit          f;
        int          base;
        a   = rs1[d] + immv[d];
        sz  = 0;
        ill = 1'b0;
        if (mw[d]) begin
            case (bhw_i[d][1:0])
                2'b00:   sz = 1;
                2'b01:   sz = 2;
                2'b10:   sz = 4;
                default: ill = 1'b1;
            endcase
        end else begin
            case (bhw_i[d])
                3'b000, 3'b100: sz = 1;
                3'b001, 3'b101: sz = 2;
                3'b010:         sz = 4;
                default:        ill = 1'b1;
            endcase
        end
        f    = ill ? 1'b1 : ((int'(a[1:0]) % sz) != 0);
        base = int'(a[11:0]);
        v    = 32'h0;
        if (!f) begin
            if (mw[d]) begin
                if (!drop_mode) begin
                    for (int k = 0; k < sz; k++) bmem[d][base + k] = rs2[d][8*k +: 8];
                end
            end else begin
                for (int k = 0; k < sz; k++) v = v | (32'(bmem[d][base + k]) << (8 * k));
                if (!bhw_i[d][2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            end
        end
        if (!drop_mode) q.push_back('{due: cyc + lat(d), tag: tagi[d], data: v, fault: f});
    endfunction

    task automatic tick(input int d, output bit acc);
        bit er;
        er = (d == 0) ? 1'b1 : (cyc >= last_acc[d] + lat(d));
        vectors++;
        if (rdy[d] !== er) begin
            errors++;
            $display("FAIL ready d%0d cyc %0d: got %b expected %b", d, cyc, rdy[d], er);
        end
        acc = en[d] && er;
        if (acc) begin
            model_accept(d);
            last_acc[d] = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].due < cyc) begin
            errors++;
            $display("FAIL missed_finish d%0d tag %0d due %0d", d, q[0].tag, q[0].due);
            void'(q.pop_front());
        end
        vectors++;
        if (q.size() > 0 && q[0].due == cyc) begin
            got_data  = md[d];
            got_tag   = tago[d];
            got_fault = flt[d];
            if (fin[d] !== 1'b1 || md[d] !== q[0].data || tago[d] !== q[0].tag
                || flt[d] !== q[0].fault) begin
                errors++;
                $display("FAIL result d%0d cyc %0d: got fin=%b data=%h tag=%0d fault=%b expected fin=1 data=%h tag=%0d fault=%b",
                         d, cyc, fin[d], md[d], tago[d], flt[d], q[0].data, q[0].tag, q[0].fault);
            end
            void'(q.pop_front());
        end else if (fin[d] !== 1'b0) begin
            errors++;
            $display("FAIL spurious_finish d%0d cyc %0d: got fin=%b tag=%0d expected fin=0", d, cyc, fin[d], tago[d]);
        end
    endtask

    task automatic drive(input int d, input bit we, input logic [2:0] b, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic [4:0] tg);
        en[d] = 1'b1; mw[d] = we; bhw_i[d] = b; rs1[d] = r1; rs2[d] = r2; immv[d] = im; tagi[d] = tg;
    endtask

    task automatic issue(input int d, input bit we, input logic [2:0] b, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic [4:0] tg);
        bit a;
        a = 1'b0;
        drive(d, we, b, r1, r2, im, tg);
        for (int i = 0; i < 10 && !a; i++) tick(d, a);
        vectors++;
        if (!a) begin
            errors++;
            $display("FAIL accept_timeout d%0d tag %0d: got no acceptance expected one within 10 cycles", d, tg);
        end
    endtask

    task automatic drain(input int d);
        bit a;
        en[d] = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(d, a);
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout d%0d: got %0d pending expected 0", d, q.size());
            q.delete();
        end
    endtask

    task automatic rand_op(input int d, input logic [4:0] tg);
        bit          we;
        logic [2:0]  b;
        int          sz;
        logic [31:0] low;
        logic [31:0] tgt;
        logic [31:0] r1;
        we = ($urandom_range(0, 2) == 0);
        if (we) begin
            b = ($urandom_range(0, 15) == 0) ? 3'b011 : {1'b0, 2'($urandom_range(0, 2))};
        end else if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
                0:       b = 3'b011;
                1:       b = 3'b110;
                default: b = 3'b111;
            endcase
        end else begin
            case ($urandom_range(0, 4))
                0:       b = 3'b000;
                1:       b = 3'b001;
                2:       b = 3'b010;
                3:       b = 3'b100;
                default: b = 3'b101;
            endcase
        end
        sz  = (b[1:0] == 2'b00) ? 1 : (b[1:0] == 2'b01) ? 2 : 4;
        low = 32'($urandom_range(0, 511));
        if ($urandom_range(0, 3) != 0) low = low & ~32'(sz - 1);
        tgt = ($urandom & 32'hFFFF_F000) | low;
        r1  = $urandom;
        drive(d, we, b, r1, $urandom, tgt - r1, tg);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) en[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (rdy[d] !== 1'b0 || fin[d] !== 1'b0 || flt[d] !== 1'b0 || md[d] !== 32'h0 || tago[d] !== 5'd0) begin
                errors++;
                $display("FAIL reset_state d%0d: got rdy=%b fin=%b fault=%b data=%h tag=%0d expected all zero",
                         d, rdy[d], fin[d], flt[d], md[d], tago[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        last_acc[0] = -100;
        last_acc[1] = -100;
    endtask

    task automatic prefill(input int d);
        for (int w = 0; w < 128; w++) begin
            logic [31:0] r1;
            r1 = $urandom;
            issue(d, 1'b1, 3'b010, r1, $urandom, 32'(4 * w) - r1, 5'(w));
        end
        drain(d);
    endtask

    task automatic test_store_load();
        issue(0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h4, 5'd1);
        issue(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h4, 5'd3);
        drain(0);
        vectors++;
        if (got_data !== 32'hDEAD_BEEF || got_tag !== 5'd3 || got_fault !== 1'b0) begin
            errors++;
            $display("FAIL store_then_load: got data=%h tag=%0d fault=%b expected deadbeef/3/0", got_data, got_tag, got_fault);
        end
    endtask

    task automatic test_extension();
        logic [2:0]  codes [5];
        logic [31:0] addrs [5];
        logic [31:0] want  [5];
        codes[0] = 3'b000; addrs[0] = 32'h21; want[0] = 32'h0000_007F;
        codes[1] = 3'b100; addrs[1] = 32'h21; want[1] = 32'h0000_007F;
        codes[2] = 3'b001; addrs[2] = 32'h22; want[2] = 32'hFFFF_80FF;
        codes[3] = 3'b101; addrs[3] = 32'h22; want[3] = 32'h0000_80FF;
        codes[4] = 3'b000; addrs[4] = 32'h20; want[4] = 32'h0000_0001;
        issue(0, 1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 32'h0, 5'd4);
        for (int i = 0; i < 5; i++) begin
            issue(0, 1'b0, codes[i], addrs[i], 32'h0, 32'h0, 5'(10 + i));
            drain(0);
            vectors++;
            if (got_data !== want[i]) begin
                errors++;
                $display("FAIL load_ext_%0d: got %h expected %h", i, got_data, want[i]);
            end
        end
        issue(0, 1'b1, 3'b000, 32'h20, 32'h1234_56AA, 32'h3, 5'd5);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h10, 5'd6);
        drain(0);
        vectors++;
        if (got_data !== 32'hAAFF_7F01) begin
            errors++;
            $display("FAIL sb_merge: got %h expected aaff7f01", got_data);
        end
    endtask

    task automatic test_faults();
        logic [2:0] fb  [4];
        bit         fwe [4];
        logic [31:0] fa [4];
        fb[0] = 3'b001; fwe[0] = 1'b0; fa[0] = 32'h101;
        fb[1] = 3'b010; fwe[1] = 1'b1; fa[1] = 32'h102;
        fb[2] = 3'b110; fwe[2] = 1'b0; fa[2] = 32'h100;
        fb[3] = 3'b011; fwe[3] = 1'b1; fa[3] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            issue(0, fwe[i], fb[i], 32'h100, 32'h5555_AAAA, fa[i] - 32'h100, 5'(20 + i));
            drain(0);
            vectors++;
            if (got_fault !== 1'b1 || got_data !== 32'h0) begin
                errors++;
                $display("FAIL fault_%0d: got fault=%b data=%h expected fault=1 data=0", i, got_fault, got_data);
            end
        end
        issue(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd25);
        drain(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) issue(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'(8 * i), 5'(i));
        drain(0);
    endtask

    task automatic test_blocking();
        bit a;
        int n_acc;
        int tg;
        n_acc = 0;
        tg    = 0;
        drive(1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1, a);
            if (a) begin
                n_acc++;
                tg++;
                drive(1, 1'b0, 3'b010, 32'h40, 32'h0, 32'(4 * tg), 5'(tg));
            end
        end
        drain(1);
        vectors++;
        if (n_acc != 3) begin
            errors++;
            $display("FAIL blocking_accepts: got %0d expected 3", n_acc);
        end
    endtask

    task automatic test_random(input int d, input int n);
        bit a;
        int tg;
        tg = 0;
        en[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!en[d] && $urandom_range(0, 3) != 0) begin
                rand_op(d, 5'(tg));
                tg++;
            end
            tick(d, a);
            if (a) en[d] = 1'b0;
        end
        drain(d);
    endtask

    task automatic test_reset_midstream();
        bit a;
        drop_mode = 1'b1;
        issue(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h180, 5'd30);
        drive(0, 1'b1, 3'b010, 32'h100, 32'hCAFE_F00D, 32'h84, 5'd31);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rdy[0] !== 1'b0 || fin[0] !== 1'b0 || flt[0] !== 1'b0 || md[0] !== 32'h0 || tago[0] !== 5'd0) begin
            errors++;
            $display("FAIL midstream_reset: got rdy=%b fin=%b fault=%b data=%h tag=%0d expected all zero",
                     rdy[0], fin[0], flt[0], md[0], tago[0]);
        end
        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        last_acc[0] = -100;
        last_acc[1] = -100;
        drop_mode = 1'b0;
        for (int i = 0; i < 4; i++) tick(0, a);
        issue(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h84, 5'd7);
        drain(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors   = 0;
        errors    = 0;
        cyc       = 0;
        drop_mode = 1'b0;
        got_data  = '0;
        got_tag   = '0;
        got_fault = 1'b0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; mw[d] = 1'b0; bhw_i[d] = '0; rs1[d] = '0; rs2[d] = '0; immv[d] = '0; tagi[d] = '0;
            last_acc[d] = -100;
            for (int k = 0; k < 4096; k++) bmem[d][k] = 8'h00;
        end
        test_reset();
        prefill(0);
        prefill(1);
        test_store_load();
        test_extension();
        test_faults();
        test_back_to_back();
        test_random(0, 400);
        test_blocking();
        test_random(1, 400);
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
